// File: rtl/udp_unpack.sv
// UDP receive unpacker: validates an IPv4/UDP frame in RX RAM and copies its payload into payload RAM.
// Latency: 15 header reads, N+1 payload cycles, then fold/check/done; completion is a one-cycle rx_valid or rx_err pulse.
// Backpressure: none; RX RAM is read at one word per cycle, and rx_start is ignored while udp_busy is high.
module udp_unpack (
  input  logic        clk,
  input  logic        RST,
  input  logic        rx_start,
  input  logic        rx_bank,
  input  logic [15:0] local_port,
  input  logic [31:0] sum_init,
  input  logic [15:0] rx_data,
  output logic [10:0] rx_rdaddr,
  output logic [15:0] pl_data,
  output logic [10:0] pl_addr,
  output logic        pl_wren,
  output logic        pl_bank,
  output logic        udp_busy,
  output logic        rx_valid,
  output logic        rx_err,
  output logic [15:0] rx_len,
  output logic [2:0]  err_code
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HDR   = 3'd1;
  localparam logic [2:0] S_PAY   = 3'd2;
  localparam logic [2:0] S_FOLD1 = 3'd3;
  localparam logic [2:0] S_FOLD2 = 3'd4;
  localparam logic [2:0] S_CHECK = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  logic [2:0]  state;
  logic        start_q;
  logic        bank;
  logic [9:0]  rd_word;    // word currently on rx_rdaddr
  logic [9:0]  dat_word;   // word whose data is on rx_data this cycle
  logic        dv;         // dat_word is meaningful (false on the first HDR cycle)
  logic [15:0] len;
  logic [9:0]  npay;
  logic [9:0]  pidx;
  logic        pay_flush;  // last payload word captured; one cycle left for its write
  logic        csum_off;
  logic [31:0] sum;

  logic [15:0] n_calc;
  logic        len_bad;
  logic        last_pay;
  logic [15:0] pay_word;
  logic [9:0]  rd_end;
  logic [2:0]  hdr_code;

  assign n_calc   = (rx_data - 16'd7) >> 1;
  assign len_bad  = (rx_data < 16'd8) || (n_calc > 16'd1003);
  assign last_pay = (pidx == npay - 10'd1);
  // An odd UDP length leaves only the high byte of the final word as payload.
  assign pay_word = (last_pay && len[0]) ? {rx_data[15:8], 8'h00} : rx_data;
  assign rd_end   = 10'd20 + npay;

  // Header field validation for the word arriving this cycle.
  always_comb begin
    hdr_code = 3'd0;
    if (dv) begin
      case (dat_word)
        10'd6:   if (rx_data != 16'h0800)      hdr_code = 3'd1;
        10'd11:  if (rx_data[7:0] != 8'h11)    hdr_code = 3'd2;
        10'd18:  if (rx_data != local_port)    hdr_code = 3'd3;
        10'd19:  if (len_bad)                  hdr_code = 3'd4;
        default: hdr_code = 3'd0;
      endcase
    end
  end

  // Frame FSM: header reads, payload copy, checksum fold and completion reporting.
  always_ff @(posedge clk) begin
    if (RST) begin
      state     <= S_IDLE;
      start_q   <= 1'b0;
      bank      <= 1'b0;
      rd_word   <= 10'd0;
      dat_word  <= 10'd0;
      dv        <= 1'b0;
      len       <= 16'd0;
      npay      <= 10'd0;
      pidx      <= 10'd0;
      pay_flush <= 1'b0;
      csum_off  <= 1'b0;
      sum       <= 32'd0;
      rx_rdaddr <= 11'd0;
      pl_data   <= 16'd0;
      pl_addr   <= 11'd0;
      pl_wren   <= 1'b0;
      pl_bank   <= 1'b0;
      udp_busy  <= 1'b0;
      rx_valid  <= 1'b0;
      rx_err    <= 1'b0;
      rx_len    <= 16'd0;
      err_code  <= 3'd0;
    end else begin
      start_q  <= rx_start;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
      pl_wren  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rx_start && !start_q) begin
            bank      <= rx_bank;
            rd_word   <= 10'd6;
            rx_rdaddr <= {rx_bank, 10'd6};
            dv        <= 1'b0;
            sum       <= sum_init;
            udp_busy  <= 1'b1;
            state     <= S_HDR;
          end
        end
        S_HDR: begin
          dv       <= 1'b1;
          dat_word <= rd_word;
          // Payload reads start before PAY so the stream has no bubble.
          if ((rd_word < 10'd20) || (rd_word > 10'd20 && rd_word < rd_end)) begin
            rd_word   <= rd_word + 10'd1;
            rx_rdaddr <= {bank, rd_word + 10'd1};
          end
          if (hdr_code != 3'd0) begin
            rx_err   <= 1'b1;
            rx_len   <= 16'd0;
            err_code <= hdr_code;
            state    <= S_DONE;
          end else if (dv) begin
            case (dat_word)
              10'd17, 10'd18: sum <= sum + {16'h0000, rx_data};
              10'd19: begin
                len  <= rx_data;
                npay <= n_calc[9:0];
                // Length counted once for the UDP header and once for the pseudo-header.
                sum  <= sum + {15'h0000, rx_data, 1'b0};
                if (n_calc != 16'd0) begin
                  rd_word   <= 10'd21;
                  rx_rdaddr <= {bank, 10'd21};
                end
              end
              10'd20: begin
                sum       <= sum + {16'h0000, rx_data};
                csum_off  <= (rx_data == 16'h0000);
                pidx      <= 10'd0;
                pay_flush <= 1'b0;
                state     <= (npay != 10'd0) ? S_PAY : S_FOLD1;
              end
              default: ;
            endcase
          end
        end
        S_PAY: begin
          if (pay_flush) begin
            state <= S_FOLD1;
          end else begin
            pl_wren <= 1'b1;
            pl_addr <= {pl_bank, pidx};
            pl_data <= pay_word;
            sum     <= sum + {16'h0000, pay_word};
            pidx    <= pidx + 10'd1;
            if (last_pay) pay_flush <= 1'b1;
            if (rd_word < rd_end) begin
              rd_word   <= rd_word + 10'd1;
              rx_rdaddr <= {bank, rd_word + 10'd1};
            end
          end
        end
        S_FOLD1, S_FOLD2: begin
          sum   <= {16'h0000, sum[31:16]} + {16'h0000, sum[15:0]};
          state <= (state == S_FOLD1) ? S_FOLD2 : S_CHECK;
        end
        S_CHECK: begin
          state <= S_DONE;
          if (csum_off || sum[15:0] == 16'hFFFF) begin
            rx_valid <= 1'b1;
            rx_len   <= len - 16'd8;
            err_code <= 3'd0;
            pl_bank  <= ~pl_bank;
          end else begin
            rx_err   <= 1'b1;
            rx_len   <= 16'd0;
            err_code <= 3'd5;
          end
        end
        S_DONE: begin
          udp_busy <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
